// File: rtl/pool_max4_reduce.sv
// Reduces a 2x2 pooling window to its maximum over a two-stage pipeline and
// tags each pooled output with end-of-row / end-of-frame flags.
module pool_max4_reduce #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5,
  parameter int NUM_FORMAT = 0   // 0: signed integer, 1: IEEE-754 single (DATA_WIDTH must be 32)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [DATA_WIDTH-1:0] i_data3,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  valid_out,
  output logic                  o_last_col,
  output logic                  o_last_frame
);

  localparam int OUT_W = (WIDTH / 2 >= 1) ? WIDTH / 2 : 1;
  localparam int OUT_H = (HEIGHT / 2 >= 1) ? HEIGHT / 2 : 1;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);
  localparam int MSB = DATA_WIDTH - 1;

  // True when operand a (the lower-index one) is selected; ties favour a.
  function automatic logic a_wins(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    logic win;
    if (NUM_FORMAT == 1) begin
      // Sign-magnitude ordering: positive beats negative (so +0 beats -0),
      // and among negatives the smaller magnitude is the larger value.
      if (a[MSB] != b[MSB])
        win = ~a[MSB];
      else if (!a[MSB])
        win = (a[MSB-1:0] >= b[MSB-1:0]);
      else
        win = (a[MSB-1:0] <= b[MSB-1:0]);
    end else begin
      win = ($signed(a) >= $signed(b));
    end
    return win;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return a_wins(a, b) ? a : b;
  endfunction

  logic [DATA_WIDTH-1:0] m01, m23;
  logic                  v1;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;

  // Stage 1: pairwise maxima of the top and bottom tap pairs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too; it costs little here and keeps
      // o_data deterministic at 0 after reset.
      m01 <= '0;
      m23 <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        m01 <= max2(i_data0, i_data1);
        m23 <= max2(i_data2, i_data3);
      end
    end
  end

  // Stage 2: final maximum, position flags and the row/column counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data       <= '0;
      valid_out    <= 1'b0;
      o_last_col   <= 1'b0;
      o_last_frame <= 1'b0;
      col_cnt      <= '0;
      row_cnt      <= '0;
    end else begin
      valid_out    <= v1;
      o_last_col   <= v1 && (col_cnt == LAST_COL);
      o_last_frame <= v1 && (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
      if (v1) begin
        o_data <= max2(m01, m23);
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_max4_reduce.sv
// Randomised scoreboard bench for pool_max4_reduce: integer and float compare
// on a 2x2 output grid, plus a 1x1 grid where every output ends a frame.
module tb_pool_max4_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d0, d1, d2, d3;
  logic        valid_in;

  logic [31:0] od_i, od_f, od_s;
  logic        vo_i, vo_f, vo_s;
  logic        lc_i, lc_f, lc_s;
  logic        lf_i, lf_f, lf_s;

  always #5 clk = ~clk;

  pool_max4_reduce #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5), .NUM_FORMAT(0)) u_int (
    .clk(clk), .rst(rst), .i_data0(d0), .i_data1(d1), .i_data2(d2), .i_data3(d3),
    .valid_in(valid_in), .o_data(od_i), .valid_out(vo_i),
    .o_last_col(lc_i), .o_last_frame(lf_i));

  pool_max4_reduce #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5), .NUM_FORMAT(1)) u_fp (
    .clk(clk), .rst(rst), .i_data0(d0), .i_data1(d1), .i_data2(d2), .i_data3(d3),
    .valid_in(valid_in), .o_data(od_f), .valid_out(vo_f),
    .o_last_col(lc_f), .o_last_frame(lf_f));

  pool_max4_reduce #(.DATA_WIDTH(32), .WIDTH(3), .HEIGHT(2), .NUM_FORMAT(0)) u_small (
    .clk(clk), .rst(rst), .i_data0(d0), .i_data1(d1), .i_data2(d2), .i_data3(d3),
    .valid_in(valid_in), .o_data(od_s), .valid_out(vo_s),
    .o_last_col(lc_s), .o_last_frame(lf_s));

  typedef struct {
    logic [31:0] e_int;
    logic [31:0] e_fp;
    int          cyc;
    bit          lc;
    bit          lf;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_win = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hold_i, hold_f, hold_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Ordering keys: signed value for integers; for floats a key where all
  // positives sit above all negatives and -0 sits just below +0.
  function automatic longint int_key(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint fp_key(input logic [31:0] x);
    return x[31] ? -longint'({1'b0, x[30:0]}) - 1 : longint'({1'b0, x[30:0]});
  endfunction

  function automatic logic [31:0] model_max(input logic [31:0] t[4], input bit fp);
    logic [31:0] best;
    best = t[0];
    for (int i = 1; i < 4; i++)
      if ((fp ? fp_key(t[i]) : int_key(t[i])) > (fp ? fp_key(best) : int_key(best)))
        best = t[i];
    return best;
  endfunction

  // Drive one cycle of stimulus and record what the design must produce.
  task automatic issue(input logic [31:0] a, b, c, d, input bit v, input bit r);
    exp_t        e;
    logic [31:0] t[4];
    int          col, row;
    @(posedge clk);
    #2;
    d0 = a; d1 = b; d2 = c; d3 = d;
    valid_in = v;
    rst = r;
    if (r) begin
      q.delete();
      n_win  = 0;
      hold_i = '0; hold_f = '0; hold_s = '0;
    end else if (v) begin
      t = '{a, b, c, d};
      col     = n_win % 2;
      row     = (n_win / 2) % 2;
      e.e_int = model_max(t, 1'b0);
      e.e_fp  = model_max(t, 1'b1);
      e.cyc   = cyc + 2;
      e.lc    = (col == 1);
      e.lf    = (col == 1) && (row == 1);
      q.push_back(e);
      n_win++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue('0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] pool[6];
    logic [7:0]  ex;
    pool = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h5, 32'hFFFF_FFFB};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return pool[$urandom_range(0, 5)];
      2: begin
        ex = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
      end
      default: return {1'($urandom_range(0, 1)), 31'h0};
    endcase
  endfunction

  // Monitor: compares every presented output against the scoreboard head and
  // checks hold/flag behaviour on idle cycles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (vo_i === 1'b1) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 32'(vo_i), 32'd0);
          end else begin
            e = q.pop_front();
            check("latency", cyc, e.cyc);
            check("int_data", od_i, e.e_int);
            check("fp_data", od_f, e.e_fp);
            check("small_data", od_s, e.e_int);
            check("fp_valid", 32'(vo_f), 32'd1);
            check("small_valid", 32'(vo_s), 32'd1);
            check("int_last_col", 32'(lc_i), 32'(e.lc));
            check("int_last_frame", 32'(lf_i), 32'(e.lf));
            check("fp_last_col", 32'(lc_f), 32'(e.lc));
            check("fp_last_frame", 32'(lf_f), 32'(e.lf));
            check("small_last_col", 32'(lc_s), 32'd1);
            check("small_last_frame", 32'(lf_s), 32'd1);
            hold_i = e.e_int; hold_f = e.e_fp; hold_s = e.e_int;
          end
        end else begin
          check("int_valid_idle", 32'(vo_i), 32'd0);
          check("fp_valid_idle", 32'(vo_f), 32'd0);
          check("small_valid_idle", 32'(vo_s), 32'd0);
          check("flags_idle", {26'd0, lc_i, lf_i, lc_f, lf_f, lc_s, lf_s}, 32'd0);
          check("int_hold", od_i, hold_i);
          check("fp_hold", od_f, hold_f);
          check("small_hold", od_s, hold_s);
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; valid_in = 1'b0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    issue('0, '0, '0, '0, 1'b0, 1'b1);
    issue('0, '0, '0, '0, 1'b1, 1'b1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_int_data", od_i, 32'd0);
    check("rst_valid", 32'(vo_i), 32'd0);
    check("rst_flags", {30'd0, lc_i, lf_i}, 32'd0);
    #1;

    // Integer windows, tie case, then idle to observe the held value.
    issue(32'd3, -32'sd7, 32'd12, 32'd5, 1'b1, 1'b0);
    idle(4);
    issue(-32'sd1, -32'sd8, -32'sd3, -32'sd2, 1'b1, 1'b0);
    issue(32'd4, 32'd4, 32'd4, 32'd4, 1'b1, 1'b0);
    // Float windows: mixed signs with -0, then all negative.
    issue(32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 32'h8000_0000, 1'b1, 1'b0);
    issue(32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC120_0000, 1'b1, 1'b0);
    idle(3);

    // Fresh frame: five back-to-back windows cross a frame boundary.
    issue('0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(3);

    // Gapped input: windows on relative cycles 0, 3, 4, 9.
    issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(2);
    issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
    issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(4);
    issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'b1, 1'b0);
    idle(3);

    // Reset one cycle after a window, reset coinciding with valid, then restart.
    issue(32'd77, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    issue('0, '0, '0, '0, 1'b0, 1'b1);
    issue(32'd9, 32'd9, 32'd9, 32'd9, 1'b1, 1'b1);
    idle(2);
    issue(32'd8, 32'd6, 32'd7, 32'd5, 1'b1, 1'b0);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2)
        issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b1);
      else
        issue(rnd_val(), rnd_val(), rnd_val(), rnd_val(), ($urandom_range(0, 99) < 70), 1'b0);
    end

    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      idle(1);
      waited++;
    end
    check("drain_pending", q.size(), 32'd0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
